// File: rtl/bmc_pkg.sv
// Shared definitions for the biphase-mark receive link: decoder state encoding and
// interval thresholds derived from the half-bit length.
package bmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FRAME_BND = 2'd1,
        ST_FRAME_MID = 2'd2,
        ST_HUNT      = 2'd3
    } bmc_state_e;

    // Counter must be able to hold the timeout value itself.
    function automatic int bmc_cnt_w(input int half_bit);
        return $clog2(3 * half_bit + 1);
    endfunction

    function automatic int bmc_short_min(input int half_bit);
        return half_bit / 2;
    endfunction

    function automatic int bmc_long_min(input int half_bit);
        return (3 * half_bit) / 2;
    endfunction

    function automatic int bmc_viol_min(input int half_bit);
        return (5 * half_bit) / 2;
    endfunction

    function automatic int bmc_timeout(input int half_bit);
        return 3 * half_bit;
    endfunction

endpackage

// File: rtl/bmc_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous line, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta_p0;
    logic r_sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_meta_p0 <= i_d;
            r_sync_p1 <= r_meta_p0;
        end
    end

    assign o_q = r_sync_p1;

endmodule

// File: rtl/bmc_rx.sv
// Biphase-mark receiver: measures edge intervals on an oversampled line, decodes MSB-first
// words and hands them to a single-entry valid/ready holding register.
module bmc_rx
    import bmc_pkg::*;
#(
    parameter int W_DATA   = 32,
    parameter int HALF_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    output logic [W_DATA-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_code,
    output logic              err_frame,
    output logic              err_overflow
);

    localparam int CW = bmc_cnt_w(HALF_BIT);
    localparam int BW = $clog2(W_DATA);
    localparam logic [CW-1:0] CNT_SHORT   = CW'(bmc_short_min(HALF_BIT));
    localparam logic [CW-1:0] CNT_LONG    = CW'(bmc_long_min(HALF_BIT));
    localparam logic [CW-1:0] CNT_VIOL    = CW'(bmc_viol_min(HALF_BIT));
    localparam logic [CW-1:0] CNT_TIMEOUT = CW'(bmc_timeout(HALF_BIT));
    localparam logic [BW-1:0] BIT_LAST    = BW'(W_DATA - 1);

    logic              w_line_p1;
    logic              r_line_p2;
    logic              w_edge;
    logic [CW-1:0]     r_cnt;
    logic              w_timeout;
    logic              w_short;
    logic              w_long;
    bmc_state_e        r_state;
    bmc_state_e        w_state_nxt;
    logic              w_start;
    logic              w_shift_en;
    logic              w_bit;
    logic              w_eos;
    logic              w_viol;
    logic              w_word_done;
    logic              w_frame_err;
    logic [W_DATA-1:0] w_word;
    logic [W_DATA-1:0] r_shift;
    logic [BW-1:0]     r_bit_cnt;
    logic [W_DATA-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_err_code;
    logic              r_err_frame;
    logic              r_err_ovf;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (serial_in),
        .o_q   (w_line_p1)
    );

    // Edge detect stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_line_p2 <= 1'b0;
        else        r_line_p2 <= w_line_p1;
    end

    assign w_edge = w_line_p1 ^ r_line_p2;

    // Counter restarts at 1 so that an edge seen N cycles later reads exactly N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_cnt <= '0;
        else if (w_edge)               r_cnt <= CW'(1);
        else if (r_cnt != CNT_TIMEOUT) r_cnt <= r_cnt + CW'(1);
    end

    assign w_timeout = !w_edge && (r_cnt == CNT_TIMEOUT - CW'(1));
    assign w_short   = (r_cnt >= CNT_SHORT) && (r_cnt < CNT_LONG);
    assign w_long    = (r_cnt >= CNT_LONG)  && (r_cnt < CNT_VIOL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_bit       = 1'b0;
        w_eos       = 1'b0;
        w_viol      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FRAME_BND;
                end
            end
            ST_FRAME_BND: begin
                if (w_edge) begin
                    if (w_short)     w_state_nxt = ST_FRAME_MID;
                    else if (w_long) w_shift_en  = 1'b1;
                    else             w_viol      = 1'b1;
                end else if (w_timeout) begin
                    w_shift_en = 1'b1;
                    w_eos      = 1'b1;
                end
            end
            ST_FRAME_MID: begin
                if (w_edge) begin
                    if (w_short) begin
                        w_shift_en  = 1'b1;
                        w_bit       = 1'b1;
                        w_state_nxt = ST_FRAME_BND;
                    end else begin
                        w_viol = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_shift_en = 1'b1;
                    w_bit      = 1'b1;
                    w_eos      = 1'b1;
                end
            end
            ST_HUNT: begin
                if (w_timeout) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_viol) w_state_nxt = ST_HUNT;
        if (w_eos)  w_state_nxt = ST_IDLE;
        w_word_done = w_shift_en && (r_bit_cnt == BIT_LAST);
        w_word      = {r_shift[W_DATA-2:0], w_bit};
        w_frame_err = w_eos && !w_word_done;
    end

    // Shift stage: a stream end or violation discards whatever partial word is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_start || w_viol || w_eos) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift   <= w_word;
            r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BW'(1);
        end
    end

    // Output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err_code  <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_err_code  <= w_viol;
            r_err_frame <= w_frame_err;
            r_err_ovf   <= 1'b0;
            if (w_word_done) begin
                if (!r_out_valid || out_ready) begin
                    r_out_data  <= w_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_err_ovf <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign busy         = (r_state == ST_FRAME_BND) || (r_state == ST_FRAME_MID);
    assign err_code     = r_err_code;
    assign err_frame    = r_err_frame;
    assign err_overflow = r_err_ovf;

endmodule
